vip_out_fifo: RTL and testbench
===============================

Name: vip_out_fifo

Overview:
- Output buffering stage between the pixel-processing pipeline and the frame/file writer stage.
- Accepts a valid/ready RGB pixel stream with start-of-frame marking and stores it in an on-chip FIFO.
- Presents a read-request FIFO interface (rdreq/data/empty, 1-cycle read latency) to the downstream consumer.
- Tracks pixel and frame position on the write side and flags framing errors and underflow.

Parameters:
- DWIDTH, 24, pixel width; packed R[23:16], G[15:8], B[7:0].
- AWIDTH, 9, FIFO address width; depth is 2**AWIDTH (512).
- DIMW, 11, width of the width/height/frame-count inputs.

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- in_data  input  DWIDTH  upstream pixel.
- in_sof  input  1  marks pixel 0 of a frame; qualified by in_valid.
- width  input  DIMW  frame width in pixels.
- height  input  DIMW  frame height in pixels.
- fifo_rdreq  input  1  consumer pop request.
- fifo_data  output  DWIDTH  popped pixel; valid the cycle after an accepted rdreq.
- fifo_empty  output  1  FIFO holds no entries.
- usedw  output  AWIDTH+1  current occupancy, 0..2**AWIDTH.
- frame_cnt  output  DIMW  frames fully written since reset.
- frame_done  output  1  one-cycle pulse when the last pixel of a frame is written.
- sof_err  output  1  sticky framing-error flag.
- underflow  output  1  sticky flag: rdreq asserted while empty.

Behaviour:
- Reset values: in_ready=0 while reset is asserted, then 1; fifo_data=0; fifo_empty=1; usedw=0; frame_cnt=0; frame_done=0; sof_err=0; underflow=0. Pointers and pixel counter are cleared.
- Reset asserted mid-operation discards all FIFO contents immediately. No partial-frame state survives.
- Write:
  - in_ready = !full, decoded from registered occupancy.
  - A pixel is accepted when in_valid && in_ready.
  - Writes are never refused on the basis of a same-cycle read, so full stays full for that cycle.
- Read:
  - A pop occurs when fifo_rdreq && !fifo_empty.
  - fifo_data is registered and updates on the edge after the pop cycle, giving 1-cycle latency.
  - fifo_data holds its last value otherwise.
  - rdreq while empty: ignored, fifo_data unchanged, underflow set (sticky).
- Simultaneous write and read:
  - When not empty and not full, usedw is unchanged.
  - When empty, only the write takes effect. There is no fall-through; fifo_empty deasserts the next cycle.
- Occupancy flags: fifo_empty and usedw are registered and reflect all writes and pops from the previous edge. Pointers wrap modulo 2**AWIDTH.
- Frame tracking (write side, on accepted pixels only):
  - pix_cnt counts 0 .. W*H-1.
  - At pix_cnt==0, width and height are latched to W and H; the 2*DIMW-bit product is precomputed.
  - When the accepted pixel has pix_cnt==W*H-1: pix_cnt returns to 0, frame_cnt increments (wraps at 2**DIMW), and frame_done pulses the next cycle.
- Framing errors (both set sort_err sticky):
  - in_sof on a pixel with pix_cnt!=0: sof_err set; the pixel is treated as pixel 0 (pix_cnt becomes 1, dimensions re-latched); frame_cnt is not incremented.
  - Pixel with pix_cnt==0 and in_sof==0: sof_err set; counting continues normally.
- Degenerate dimensions: W or H equal to 0 is treated as 1.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: VIP_OUT_FIFO_STATS_EN.
- With the macro defined, two extra output ports are present:
  - hwm (AWIDTH+1 bits): maximum usedw since reset, updated each cycle.
  - stall_cnt (16 bits, saturating): cycles with in_valid && !in_ready.
- Without the macro, these ports and their logic are absent. All other behaviour is identical.

Decomposition:
- vip_pkg holds:
  - PIXEL_W=24 and the R/G/B slice constants.
  - DIM_W=11.
  - The shared pixel typedef.
- Sub-module vip_sync_fifo_ram: a simple dual-port 2**AWIDTH x DWIDTH array with one registered write port and one registered read port.
- Pointer, flag and frame logic live in vip_out_fifo.

Test Plan:
- Fill: width=4, height=2, 8 pixels 0x010203.. with in_sof on the first, no reads -> usedw=8, frame_done pulses once, frame_cnt=1, sof_err=0.
- Drain: pop all 8 with continuous rdreq -> fifo_data matches write order, each value one cycle after its rdreq; fifo_empty=1 after the 8th pop; one extra rdreq sets underflow and fifo_data holds the 8th value.
- Full: write 512 pixels with no reads -> in_ready=0 and usedw=512; then rdreq and in_valid in the same cycle -> write refused, usedw=511, in_ready=1 next cycle.
- Empty simultaneity: empty FIFO, write and rdreq in the same cycle -> no pop, usedw=1, fifo_data unchanged.
- Framing: width=4, height=2, in_sof on the 3rd pixel -> sof_err=1, next frame_done after 8 more accepted pixels counting from that pixel.
- Reset mid-stream: reset asserted with usedw=100 -> same cycle fifo_empty=1, usedw=0, frame_cnt=0, flags cleared.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared pixel and dimension definitions for the video output path.
// Packed pixel layout is R in the top byte, B in the bottom byte.
package vip_pkg;

    localparam int PIXEL_W = 24;
    localparam int R_HI    = 23;
    localparam int R_LO    = 16;
    localparam int G_HI    = 15;
    localparam int G_LO    = 8;
    localparam int B_HI    = 7;
    localparam int B_LO    = 0;

    localparam int DIM_W   = 11;

    typedef logic [PIXEL_W-1:0] pixel_t;

endpackage

// File: rtl/vip_sync_fifo_ram.sv
// Simple dual-port pixel store with one registered write port and one
// registered read port; the read register clears on reset.
module vip_sync_fifo_ram
    import vip_pkg::*;
#(
    parameter int DWIDTH = PIXEL_W,
    parameter int AWIDTH = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vip_out_fifo.sv
// Output pixel FIFO with write-side frame tracking and sticky error flags.
// Define VIP_OUT_FIFO_STATS_EN to add the hwm and stall_cnt outputs.
module vip_out_fifo
    import vip_pkg::*;
#(
    parameter int DWIDTH = PIXEL_W,
    parameter int AWIDTH = 9,
    parameter int DIMW   = DIM_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sof,
    input  logic [DIMW-1:0]   width,
    input  logic [DIMW-1:0]   height,
    input  logic              fifo_rdreq,
    output logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_empty,
    output logic [AWIDTH:0]   usedw,
`ifdef VIP_OUT_FIFO_STATS_EN
    output logic [AWIDTH:0]   hwm,
    output logic [15:0]       stall_cnt,
`endif
    output logic [DIMW-1:0]   frame_cnt,
    output logic              frame_done,
    output logic              sof_err,
    output logic              underflow
);

    localparam logic [AWIDTH:0]     FULL_CNT = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]     CNT_ONE  = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0]   PTR_ONE  = {{(AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIMW-1:0]     DIM_ONE  = {{(DIMW-1){1'b0}}, 1'b1};
    localparam logic [2*DIMW-1:0]   PIX_ONE  = {{(2*DIMW-1){1'b0}}, 1'b1};

    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   count;
    logic [AWIDTH:0]   count_next;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    // Full is decoded from the registered count only, so a same-cycle pop
    // never opens a write slot.
    assign full       = (count == FULL_CNT);
    assign in_ready   = !reset && !full;
    assign wr_en      = in_valid && in_ready;
    assign rd_en      = fifo_rdreq && !fifo_empty;
    assign usedw      = count;

    always_comb begin
        count_next = count;
        case ({wr_en, rd_en})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_empty <= 1'b1;
            underflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
            count      <= count_next;
            fifo_empty <= (count_next == '0);
            if (fifo_rdreq && fifo_empty) underflow <= 1'b1;
        end
    end

    vip_sync_fifo_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (fifo_data)
    );

    logic [DIMW-1:0]   w_eff;
    logic [DIMW-1:0]   h_eff;
    logic [2*DIMW-1:0] pix_cnt;
    logic [2*DIMW-1:0] total_q;
    logic [2*DIMW-1:0] total_new;
    logic [2*DIMW-1:0] total;
    logic [2*DIMW-1:0] idx;
    logic              start;
    logic              last;

    // An sof mid-frame restarts the frame at this pixel.
    always_comb begin
        w_eff     = (width == '0) ? DIM_ONE : width;
        h_eff     = (height == '0) ? DIM_ONE : height;
        total_new = {{DIMW{1'b0}}, w_eff} * {{DIMW{1'b0}}, h_eff};
        start     = (pix_cnt == '0) || in_sof;
        total     = start ? total_new : total_q;
        idx       = start ? '0 : pix_cnt;
        last      = (idx == total - PIX_ONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_cnt    <= '0;
            total_q    <= PIX_ONE;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            frame_done <= wr_en && last;
            if (wr_en) begin
                if (start) total_q <= total_new;
                pix_cnt <= last ? '0 : idx + PIX_ONE;
                if (last) frame_cnt <= frame_cnt + DIM_ONE;
                if (in_sof != (pix_cnt == '0)) sof_err <= 1'b1;
            end
        end
    end

`ifdef VIP_OUT_FIFO_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hwm       <= '0;
            stall_cnt <= '0;
        end else begin
            if (count > hwm) hwm <= count;
            if (in_valid && !in_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vip_out_fifo.sv
// Directed bench for vip_out_fifo with a queue-based reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_vip_out_fifo;

    localparam int DEPTH = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_data = '0;
    logic        in_sof = 1'b0;
    logic [10:0] width = 11'd4;
    logic [10:0] height = 11'd2;
    logic        fifo_rdreq = 1'b0;
    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic [9:0]  usedw;
    logic [10:0] frame_cnt;
    logic        frame_done;
    logic        sof_err;
    logic        underflow;
`ifdef VIP_OUT_FIFO_STATS_EN
    logic [9:0]  hwm;
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    vip_out_fifo dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .width      (width),
        .height     (height),
        .fifo_rdreq (fifo_rdreq),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .usedw      (usedw),
`ifdef VIP_OUT_FIFO_STATS_EN
        .hwm        (hwm),
        .stall_cnt  (stall_cnt),
`endif
        .frame_cnt  (frame_cnt),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .underflow  (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int eff(input logic [10:0] d);
        return (d == 11'd0) ? 1 : int'(d);
    endfunction

    // Reference model: a queue of stored pixels and a per-frame countdown.
    logic [23:0] q[$];
    logic [23:0] m_data = '0;
    bit          m_under = 0;
    bit          m_done = 0;
    bit          m_serr = 0;
    int          m_fcnt = 0;
    int          m_left = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            q.delete();
            m_data  = '0;
            m_under = 0;
            m_done  = 0;
            m_serr  = 0;
            m_fcnt  = 0;
            m_left  = 0;
        end else begin
            bit pop;
            bit push;
            pop    = fifo_rdreq && (q.size() != 0);
            push   = in_valid && (q.size() < DEPTH);
            m_done = 0;
            if (fifo_rdreq && q.size() == 0) m_under = 1;
            if (pop) m_data = q.pop_front();
            if (push) begin
                q.push_back(in_data);
                if (in_sof != (m_left == 0)) m_serr = 1;
                if (in_sof || m_left == 0) m_left = eff(width) * eff(height);
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_fcnt = (m_fcnt + 1) % 2048;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("m_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            check("m_empty", 32'(fifo_empty), 32'(q.size() == 0));
            check("m_usedw", 32'(usedw), 32'(q.size()));
            check("m_data", 32'(fifo_data), 32'(m_data));
            check("m_frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
            check("m_frame_done", 32'(frame_done), 32'(m_done));
            check("m_sof_err", 32'(sof_err), 32'(m_serr));
            check("m_underflow", 32'(underflow), 32'(m_under));
        end
    end

    initial begin
        #1 reset = 1'b1;
        @(posedge clock);
        #2;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_usedw", 32'(usedw), 0);
        check("rst_data", 32'(fifo_data), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_sof_err", 32'(sof_err), 0);
        check("rst_underflow", 32'(underflow), 0);
        step();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(in_ready), 1);

        // fill one 4x2 frame
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h010203 + 24'(i) * 24'h010101;
            in_sof   = (i == 0);
            step();
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("fill_usedw", 32'(usedw), 8);
        check("fill_done", 32'(frame_done), 1);
        check("fill_frame_cnt", 32'(frame_cnt), 1);
        check("fill_sof_err", 32'(sof_err), 0);
        step();
        check("fill_done_end", 32'(frame_done), 0);

        // drain in order with one-cycle latency
        fifo_rdreq = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("drain_data", 32'(fifo_data),
                  32'(24'h010203 + 24'(k) * 24'h010101));
        end
        check("drain_empty", 32'(fifo_empty), 1);
        step();
        fifo_rdreq = 1'b0;
        check("drain_underflow", 32'(underflow), 1);
        check("drain_hold", 32'(fifo_data), 32'h08090A);

        // write and read together while empty
        in_valid   = 1'b1;
        in_data    = 24'hAABBCC;
        in_sof     = 1'b1;
        fifo_rdreq = 1'b1;
        step();
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        fifo_rdreq = 1'b0;
        check("esim_usedw", 32'(usedw), 1);
        check("esim_empty", 32'(fifo_empty), 0);
        check("esim_data", 32'(fifo_data), 32'h08090A);
        fifo_rdreq = 1'b1;
        step();
        fifo_rdreq = 1'b0;
        check("esim_pop", 32'(fifo_data), 32'hAABBCC);
        check("esim_usedw0", 32'(usedw), 0);

        // fill to capacity
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = {8'h5A, 16'(i)};
            in_sof   = (i % 8 == 7);
            step();
        end
        in_data = 24'h123456;
        in_sof  = 1'b0;
        check("full_ready", 32'(in_ready), 0);
        check("full_usedw", 32'(usedw), 512);
        check("full_frame_cnt", 32'(frame_cnt), 65);
        fifo_rdreq = 1'b1;
        step();
        in_valid = 1'b0;
        check("full_rw_usedw", 32'(usedw), 511);
        check("full_rw_ready", 32'(in_ready), 1);
        check("full_rw_data", 32'(fifo_data), 32'h5A0000);
        for (int i = 0; i < DEPTH - 1; i++) step();
        fifo_rdreq = 1'b0;
        check("full_drained", 32'(fifo_empty), 1);
        check("full_last", 32'(fifo_data), 32'h5A01FF);

        // reset with data in flight, no sof anywhere
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 24'h300000 + 24'(i);
            in_sof   = 1'b0;
            step();
        end
        in_valid = 1'b0;
        check("pre_rst_usedw", 32'(usedw), 100);
        check("pre_rst_sof_err", 32'(sof_err), 1);
        check("pre_rst_frame_cnt", 32'(frame_cnt), 77);
        reset = 1'b1;
        #1;
        check("mid_rst_empty", 32'(fifo_empty), 1);
        check("mid_rst_usedw", 32'(usedw), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_sof_err", 32'(sof_err), 0);
        check("mid_rst_underflow", 32'(underflow), 0);
        check("mid_rst_ready", 32'(in_ready), 0);
        check("mid_rst_data", 32'(fifo_data), 0);
        step();
        reset = 1'b0;

        // sof on the third pixel restarts the frame there
        for (int j = 0; j < 10; j++) begin
            in_valid = 1'b1;
            in_data  = 24'h700000 + 24'(j);
            in_sof   = (j == 0 || j == 2);
            step();
            check("frm_done", 32'(frame_done), 32'(j == 9));
            check("frm_sof_err", 32'(sof_err), 32'(j >= 2));
            check("frm_cnt", 32'(frame_cnt), 32'(j == 9));
        end

        // zero dimensions behave as one
        width   = 11'd0;
        height  = 11'd0;
        in_sof  = 1'b1;
        in_data = 24'h7F0000;
        step();
        check("deg_done", 32'(frame_done), 1);
        check("deg_cnt", 32'(frame_cnt), 2);
        step();
        check("deg_cnt2", 32'(frame_cnt), 3);
        height = 11'd3;
        for (int j = 0; j < 3; j++) begin
            in_sof = (j == 0);
            step();
            check("deg_col_done", 32'(frame_done), 32'(j == 2));
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        check("deg_col_cnt", 32'(frame_cnt), 4);
        step();
        check("deg_done_end", 32'(frame_done), 0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
